sync_fifo_flags: RTL

- Parametrised single-clock FIFO, the successor to the basic synchronous FIFO.
- Adds configurable depth (not restricted to powers of two), occupancy count, programmable almost-full and almost-empty thresholds, and a selectable first-word-fall-through (FWFT) read mode.
- Adds sticky overflow/underflow status and a synchronous flush.
- Sits between producer and consumer blocks in the same clock domain.

---
 rtl/sync_fifo_pkg.sv | 13 +
 rtl/fifo_ptr.sv | 38 +++
 rtl/sync_fifo_flags.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the flagged synchronous FIFO: pointer wrap arithmetic
// and default threshold offsets.
package sync_fifo_pkg;

    localparam int unsigned AF_OFFSET  = 2;
    localparam int unsigned AE_DEFAULT = 2;

    // Explicit wrap so any DEPTH (not only powers of two) works.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer counter for the FIFO; one instance each for the write
// and read sides.
module fifo_ptr
    import sync_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          adv,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (adv) begin
            ptr_d = PW'(ptr_next(32'(ptr_q), DEPTH));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky
// error status, synchronous flush and optional first-word-fall-through read.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_LEVEL  = DEPTH - AF_OFFSET,
    parameter int unsigned AE_LEVEL  = AE_DEFAULT,
    parameter bit          FWFT      = 1'b0,
    parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rdata,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 wr_error,
    output logic                 rd_error,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_AF   = CNT_WIDTH'(AF_LEVEL);
    localparam logic [CNT_WIDTH-1:0] CNT_AE   = CNT_WIDTH'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic empty_q, empty_d;
    logic full_q, full_d;
    logic ae_q, ae_d;
    logic af_q, af_d;
    logic wr_err_q, wr_err_d;
    logic rd_err_q, rd_err_d;
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    logic wr_ok;
    logic rd_ok;

    // Acceptance uses registered flags only; flush overrides both requests.
    assign wr_ok = wr_en & ~full_q  & ~flush;
    assign rd_ok = rd_en & ~empty_q & ~flush;

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .adv   (wr_ok),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .adv   (rd_ok),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr] <= wdata;
        end
    end

    always_comb begin
        count_d  = count_q;
        wr_err_d = 1'b0;
        rd_err_d = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (flush) begin
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (wr_ok && !rd_ok) begin
                count_d = count_q + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - 1'b1;
            end
            wr_err_d = wr_en & full_q;
            rd_err_d = rd_en & empty_q;
            ovf_d    = ovf_q | wr_err_d;
            unf_d    = unf_q | rd_err_d;
        end
        // Flags derive from next-count so they move on the same edge as count.
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_FULL);
        ae_d    = (count_d <= CNT_AE);
        af_d    = (count_d >= CNT_AF);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= (AF_LEVEL == 0);
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    if (FWFT) begin : g_fwft
        // Guard keeps rdata at zero whenever nothing valid is at the head.
        assign rdata = empty_q ? '0 : mem_q[rd_ptr];
    end else begin : g_reg
        logic [WIDTH-1:0] rdata_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rdata_q <= '0;
            end else if (rd_ok) begin
                rdata_q <= mem_q[rd_ptr];
            end
        end

        assign rdata = rdata_q;
    end

    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign wr_error     = wr_err_q;
    assign rd_error     = rd_err_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
